// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver core, with sticky overrun/frame-error
// status, a level-threshold interrupt and a character-timeout interrupt.
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic                       uart_clk,
  input  logic                       rst,
  input  logic                       sample_tick,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_frame_error,
  input  logic                       rx_active,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  input  logic [$clog2(DEPTH):0]     threshold,
  output logic                       threshold_irq,
  output logic                       timeout_irq,
  output logic                       overrun,
  output logic                       frame_err,
  input  logic                       status_clr,
  input  logic                       flush
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [LW-1:0] LvlFull = LW'(DEPTH);
  localparam logic [TW-1:0] ToMax   = TW'(TIMEOUT_TICKS);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  ready_q, fe_prev_q, fe_prev_d;
  logic                  overrun_q, overrun_d, frame_err_q, frame_err_d, thr_irq_q, thr_irq_d;
  logic                  full, empty, push_req, pop_req, do_push, do_pop, ovr_set, fe_set;

  assign full      = (level_q == LvlFull);
  assign empty     = (level_q == '0);
  assign push_req  = sample_tick && in_valid;
  assign pop_req   = !empty && out_ready;
  // Flush overrides both sides; a dropped byte during flush is not an overrun.
  assign do_push   = push_req && (!full || pop_req) && !flush;
  assign do_pop    = pop_req && !flush;
  assign ovr_set   = push_req && full && !pop_req && !flush;
  assign fe_set    = sample_tick && in_frame_error && !fe_prev_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    to_cnt_d    = to_cnt_q;
    fe_prev_d   = sample_tick ? in_frame_error : fe_prev_q;
    overrun_d   = ovr_set | (overrun_q & ~status_clr);
    frame_err_d = fe_set | (frame_err_q & ~status_clr);
    thr_irq_d   = (threshold != '0) && (level_q >= threshold);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_d = level_q + LW'(1);
      else if (do_pop && !do_push) level_d = level_q - LW'(1);
    end
    if (do_push || do_pop || flush || empty || rx_active) begin
      to_cnt_d = '0;
    end else if (sample_tick && (to_cnt_q != ToMax)) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      to_cnt_q    <= '0;
      ready_q     <= 1'b0;
      fe_prev_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      thr_irq_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      to_cnt_q    <= to_cnt_d;
      ready_q     <= 1'b1;
      fe_prev_q   <= fe_prev_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      thr_irq_q   <= thr_irq_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge uart_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready      = ready_q;
  assign out_valid     = !empty;
  assign out_data      = empty ? '0 : mem_q[rd_ptr_q];
  assign level         = level_q;
  assign threshold_irq = thr_irq_q;
  assign timeout_irq   = (to_cnt_q == ToMax);
  assign overrun       = overrun_q;
  assign frame_err     = frame_err_q;

endmodule
